twiddle_fetch_seq: RTL and testbench

//  Reader/sequencer for the IFFT twiddle ROMs. On a start command it walks the selected stage's address

---
 rtl/tw_pkg.sv | 35 +++
 rtl/tw_skid_fifo.sv | 55 +++++
 rtl/twiddle_fetch_seq.sv | 117 +++++++++++
 tb/tb_twiddle_fetch_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tw_pkg.sv
// Shared constants, stage table and FSM state type for the IFFT twiddle ROM sequencer.
package tw_pkg;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 16;
  localparam int REP_W      = 5;
  localparam int FIFO_D     = 2;
  localparam int NUM_STAGES = 5;

  localparam logic [ADDR_W-1:0] STAGE_BASE [NUM_STAGES] = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd16};
  localparam logic [ADDR_W-1:0] STAGE_LEN  [NUM_STAGES] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd12};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic stage_ok(input logic [2:0] s);
    return s < 3'(NUM_STAGES);
  endfunction

  function automatic logic [ADDR_W-1:0] stage_base(input logic [2:0] s);
    logic [ADDR_W-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (s == 3'(i)) b = STAGE_BASE[i];
    return b;
  endfunction

  function automatic logic [ADDR_W-1:0] stage_end(input logic [2:0] s);
    logic [ADDR_W-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (s == 3'(i)) e = STAGE_BASE[i] + STAGE_LEN[i] - ADDR_W'(1);
    return e;
  endfunction

endpackage

// File: rtl/tw_skid_fifo.sv
// Two-entry valid/ready FIFO carrying {last, re, im}; exposes its fill count for credit-based issue.
module tw_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_last,
  input  logic [DATA_W-1:0] push_re,
  input  logic [DATA_W-1:0] push_im,
  input  logic              pop,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] re_mem [2];
  logic [DATA_W-1:0] im_mem [2];
  logic [1:0]        last_mem;
  logic              wr_ptr;
  logic              rd_ptr;

  assign out_valid = (count != 2'd0);
  assign out_last  = last_mem[rd_ptr];
  assign out_re    = re_mem[rd_ptr];
  assign out_im    = im_mem[rd_ptr];

  // Storage is cleared on reset so the stream outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      re_mem[0] <= '0;
      re_mem[1] <= '0;
      im_mem[0] <= '0;
      im_mem[1] <= '0;
      last_mem  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      assert (!(push && !pop && count == 2'd2));
      assert (!(pop && count == 2'd0));
      if (push) begin
        re_mem[wr_ptr]   <= push_re;
        im_mem[wr_ptr]   <= push_im;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/twiddle_fetch_seq.sv
// Walks a stage's twiddle ROM range (with replay), captures registered ROM data and streams (re, im) pairs.
module twiddle_fetch_seq
  import tw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        stage_sel,
  input  logic [REP_W-1:0]  rep_cnt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re_data,
  input  logic [DATA_W-1:0] rom_im_data,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic              tw_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] held_addr;
  logic [REP_W-1:0]  rep_left;
  logic              vld_p1;
  logic              last_p1;
  logic [1:0]        fifo_count;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic [2:0]        credit;

  // A slot is claimed only if the FIFO can still hold it after everything already in flight lands.
  assign pop        = tw_valid & tw_ready;
  assign credit     = 3'(fifo_count) - 3'(pop) + 3'(vld_p1) + 3'd1;
  assign issue      = (state == RUN) && (credit <= 3'(FIFO_D));
  assign issue_last = (addr_p0 == end_addr) && (rep_left == REP_W'(1));
  assign rom_addr   = issue ? addr_p0 : held_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_p0   <= '0;
      base_addr <= '0;
      end_addr  <= '0;
      held_addr <= '0;
      rep_left  <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      vld_p1  <= issue;
      last_p1 <= issue && issue_last;
      if (issue) begin
        held_addr <= addr_p0;
        if (addr_p0 == end_addr) begin
          addr_p0  <= base_addr;
          rep_left <= rep_left - REP_W'(1);
        end else begin
          addr_p0 <= addr_p0 + ADDR_W'(1);
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (stage_ok(stage_sel)) begin
              base_addr <= stage_base(stage_sel);
              addr_p0   <= stage_base(stage_sel);
              end_addr  <= stage_end(stage_sel);
              rep_left  <= (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && tw_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p1 -> output: ROM data lands one cycle after its address ----
  tw_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_last (last_p1),
    .push_re   (rom_re_data),
    .push_im   (rom_im_data),
    .pop       (pop),
    .out_valid (tw_valid),
    .out_last  (tw_last),
    .out_re    (tw_re),
    .out_im    (tw_im),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Bench for twiddle_fetch_seq: ROM model, command vector table, random commands and corner sequences.
module tb_twiddle_fetch_seq;
  import tw_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        stage_sel;
  logic [REP_W-1:0]  rep_cnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_re_data;
  logic [DATA_W-1:0] rom_im_data;
  logic              tw_valid;
  logic              tw_ready;
  logic [DATA_W-1:0] tw_re;
  logic [DATA_W-1:0] tw_im;
  logic              tw_last;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  twiddle_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start), .stage_sel(stage_sel), .rep_cnt(rep_cnt),
    .rom_addr(rom_addr), .rom_re_data(rom_re_data), .rom_im_data(rom_im_data),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
    .tw_last(tw_last), .busy(busy), .done(done), .err(err)
  );

  logic [DATA_W-1:0] rom_re [32];
  logic [DATA_W-1:0] rom_im [32];
  always @(posedge clk) begin
    rom_re_data <= rom_re[rom_addr];
    rom_im_data <= rom_im[rom_addr];
  end

  typedef struct { logic [DATA_W-1:0] re; logic [DATA_W-1:0] im; logic last; } pair_t;
  typedef struct { int st; int rep; int pct; int stall_lo; int stall_hi; int exp_pairs; } vec_t;

  int tb_base [5] = '{0, 4, 8, 12, 16};
  int tb_len  [5] = '{4, 4, 4, 4, 12};
  logic [DATA_W-1:0] s4_im [12] = '{16'h0100, 16'h00FB, 16'h00EC, 16'h00D4, 16'h00C5, 16'h00B5,
                                    16'h00A2, 16'h0092, 16'h0080, 16'h006A, 16'h0054, 16'h003E};

  int n_checks = 0;
  int n_fail   = 0;
  pair_t exp_q[$];
  pair_t got_q[$];
  int cyc = 0, cur_k = -1, first_hs, last_hs, done_cyc, done_cnt, first_valid_k;
  logic busy_at_done;
  logic prev_stall = 1'b0;
  logic [32:0] prev_word = '0;
  int addr_log [64];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // One clock: observe the settled cycle (handshakes, stream hold, done), then advance past the edge.
  task automatic step();
    #1;
    cyc++;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(tw_valid), 64'd1);
        chk("hold_data", 64'({tw_last, tw_re, tw_im}), 64'(prev_word));
      end
      if (tw_valid && tw_ready) begin
        got_q.push_back('{tw_re, tw_im, tw_last});
        if (first_hs < 0) first_hs = cyc;
        if (tw_last) last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (tw_valid && first_valid_k < 0) first_valid_k = cur_k;
      if (cur_k >= 0 && cur_k < 64) addr_log[cur_k] = int'(rom_addr);
      prev_stall = tw_valid && !tw_ready;
      prev_word  = {tw_last, tw_re, tw_im};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int st, input int rep);
    int n;
    exp_q.delete();
    n = (rep == 0) ? 1 : rep;
    for (int r = 0; r < n; r++)
      for (int i = 0; i < tb_len[st]; i++)
        exp_q.push_back('{rom_re[tb_base[st] + i], rom_im[tb_base[st] + i],
                          (r == n - 1) && (i == tb_len[st] - 1)});
  endtask

  task automatic run_cmd(input string tag, input int st, input int rep, input int pct,
                         input int stall_lo, input int stall_hi);
    int k;
    build_exp(st, rep);
    got_q.delete();
    first_hs = -1; last_hs = -1; done_cyc = -1; done_cnt = 0; first_valid_k = -1; busy_at_done = 1'b1;
    stage_sel = 3'(st);
    rep_cnt   = REP_W'(rep);
    start     = 1'b1;
    tw_ready  = ($urandom_range(0, 99) < pct);
    cur_k     = 0;
    step();
    start = 1'b0;
    chk({tag, "_busy_on"}, 64'(busy), 64'd1);
    k = 1;
    while (done_cyc < 0 && k < 1500) begin
      tw_ready = (k >= stall_lo && k <= stall_hi) ? 1'b0 : ($urandom_range(0, 99) < pct);
      cur_k = k;
      step();
      k++;
    end
    cur_k = -1;
    chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    chk({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_hs + 1));
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_npairs"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_pair%0d", tag, i), 64'({got_q[i].last, got_q[i].re, got_q[i].im}),
          64'({exp_q[i].last, exp_q[i].re, exp_q[i].im}));
  endtask

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 32; a++) begin
      rom_re[a] = 16'h0A00 + 16'(a);
      if (a < 16)      rom_im[a] = (a % 2 == 1) ? 16'h0100 : 16'h0000;
      else if (a < 28) rom_im[a] = s4_im[a - 16];
      else             rom_im[a] = 16'h0000;
    end
    vecs[0] = '{1, 1, 100, 0, -1, 4};
    vecs[1] = '{4, 1, 100, 0, -1, 12};
    vecs[2] = '{1, 3, 50, 0, -1, 12};
    vecs[3] = '{2, 1, 100, 4, 13, 4};
    vecs[4] = '{0, 0, 100, 0, -1, 4};
    vecs[5] = '{3, 2, 70, 0, -1, 8};
    vecs[6] = '{4, 3, 30, 0, -1, 36};

    rst = 1'b1; start = 1'b0; stage_sel = '0; rep_cnt = '0; tw_ready = 1'b0;
    repeat (3) step();
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_valid", 64'(tw_valid), 64'd0);
    chk("rst_data", 64'({tw_last, tw_re, tw_im}), 64'd0);
    chk("rst_ctrl", 64'({busy, done, err}), 64'd0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      run_cmd($sformatf("vec%0d", v), vecs[v].st, vecs[v].rep, vecs[v].pct,
              vecs[v].stall_lo, vecs[v].stall_hi);
      chk($sformatf("vec%0d_count", v), 64'(got_q.size()), 64'(vecs[v].exp_pairs));
      if (v == 0) begin
        for (int i = 0; i < 4; i++) chk($sformatf("s1_addr%0d", i), 64'(addr_log[i + 1]), 64'(4 + i));
        chk("s1_first_valid", 64'(first_valid_k), 64'd3);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
          chk($sformatf("s1_im%0d", i), 64'(got_q[i].im), (i % 2 == 1) ? 64'h100 : 64'h0);
      end
      if (v == 1) begin
        chk("s4_no_bubble", 64'(last_hs - first_hs), 64'd11);
        if (got_q.size() == 12) begin
          chk("s4_im_first", 64'(got_q[0].im), 64'h100);
          chk("s4_im_last", 64'(got_q[11].im), 64'h3E);
        end
      end
      if (v == 3)
        for (int k = 4; k <= 13; k++) chk($sformatf("stall_addr_k%0d", k), 64'(addr_log[k]), 64'd10);
      step();
    end

    // Bad stage: error pulse only, address bus keeps the last issued stage-4 address.
    tw_ready = 1'b1; stage_sel = 3'd6; rep_cnt = REP_W'(1); start = 1'b1;
    step();
    start = 1'b0;
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_addr", 64'(rom_addr), 64'(tb_base[4] + tb_len[4] - 1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bad_err_pulse", 64'(err), 64'd0);
      chk("bad_no_valid", 64'(tw_valid), 64'd0);
      chk("bad_addr_hold", 64'(rom_addr), 64'(tb_base[4] + tb_len[4] - 1));
    end

    for (int r = 0; r < 4; r++)
      run_cmd($sformatf("rnd%0d", r), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(20, 100)), 0, -1);

    // Reset in the middle of stage 4, then a clean stage-0 command.
    got_q.delete();
    tw_ready = 1'b1; stage_sel = 3'd4; rep_cnt = REP_W'(1); start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && got_q.size() < 5; i++) step();
    chk("mid_pairs", 64'(got_q.size()), 64'd5);
    rst = 1'b1;
    step();
    chk("mid_rst_addr", 64'(rom_addr), 64'd0);
    chk("mid_rst_valid", 64'(tw_valid), 64'd0);
    chk("mid_rst_data", 64'({tw_last, tw_re, tw_im}), 64'd0);
    chk("mid_rst_ctrl", 64'({busy, done, err}), 64'd0);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_valid", 64'(tw_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_cmd("post_rst", 0, 1, 100, 0, -1);
    chk("post_rst_count", 64'(got_q.size()), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
